// File: rtl/instr_load_sequencer.sv
// Instruction-register feeder: buffers words in a small FIFO and issues them
// as counted, address-incrementing load strobes; flags DIV/MOD by zero.
module instr_load_sequencer #(
    parameter int OPC_W   = 4,
    parameter int OPND_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 4,
    parameter int OPC_DIV = 4,
    parameter int OPC_MOD = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPC_W-1:0]    in_opcode,
    input  logic [OPND_W-1:0]   in_operand_a,
    input  logic [OPND_W-1:0]   in_operand_b,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     load_count,
    input  logic                abort,
    output logic                load_en,
    output logic [ADDR_W-1:0]   write_pointer,
    output logic [OPC_W-1:0]    opcode,
    output logic [OPND_W-1:0]   operand_a,
    output logic [OPND_W-1:0]   operand_b,
    output logic                busy,
    output logic                done,
    output logic                div0_err,
    output logic [ADDR_W:0]     loads_issued
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CW    = ADDR_W + 1;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               full, empty;
    logic               push, pop, start_ok;
    entry_t             head;
    logic               head_div0;

    logic [ADDR_W-1:0]  addr_q;
    logic [CW-1:0]      remain_q;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full && !abort;
    assign pop       = (state_q == RUN) && !empty && !abort;
    assign start_ok  = (state_q == IDLE) && start && !abort;
    assign head      = mem[rd_q];
    assign head_div0 = ((head.opc == OPC_W'(OPC_DIV)) ||
                        (head.opc == OPC_W'(OPC_MOD))) &&
                       (head.b == '0);
    assign busy      = (state_q == RUN);

    // Storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= '{opc: in_opcode, a: in_operand_a, b: in_operand_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (abort) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN:  if (pop && remain_q == CW'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_en       <= 1'b0;
            write_pointer <= '0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            done          <= 1'b0;
            div0_err      <= 1'b0;
            loads_issued  <= '0;
            addr_q        <= '0;
            remain_q      <= '0;
        end else begin
            load_en <= pop;
            done    <= 1'b0;
            if (start_ok) begin
                addr_q       <= start_addr;
                // A zero count means a full pass over the register file.
                remain_q     <= (load_count == '0) ? CW'(2 ** ADDR_W)
                                                   : load_count;
                loads_issued <= '0;
                div0_err     <= 1'b0;
            end
            if (pop) begin
                write_pointer <= addr_q;
                opcode        <= head.opc;
                operand_a     <= head.a;
                operand_b     <= head.b;
                addr_q        <= addr_q + ADDR_W'(1);
                remain_q      <= remain_q - CW'(1);
                loads_issued  <= loads_issued + CW'(1);
                done          <= (remain_q == CW'(1));
                if (head_div0) div0_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_load_sequencer.sv
// Directed bench for instr_load_sequencer: preload, wrap, gaps, div0,
// abort and asynchronous reset, with hand-computed expectations.
module tb_instr_load_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_operand_a;
    logic [31:0] in_operand_b;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  load_count;
    logic        abort;
    logic        load_en;
    logic [4:0]  write_pointer;
    logic [3:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div0_err;
    logic [5:0]  loads_issued;

    int n_checks = 0;
    int n_errors = 0;

    instr_load_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_operand_a  (in_operand_a),
        .in_operand_b  (in_operand_b),
        .start         (start),
        .start_addr    (start_addr),
        .load_count    (load_count),
        .abort         (abort),
        .load_en       (load_en),
        .write_pointer (write_pointer),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .busy          (busy),
        .done          (done),
        .div0_err      (div0_err),
        .loads_issued  (loads_issued)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b);
        in_valid     = 1'b1;
        in_opcode    = o;
        in_operand_a = a;
        in_operand_b = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load_en"}, 64'(load_en), 64'd0);
        check({tag, "_wp"}, 64'(write_pointer), 64'd0);
        check({tag, "_opc"}, 64'(opcode), 64'd0);
        check({tag, "_a"}, 64'(operand_a), 64'd0);
        check({tag, "_b"}, 64'(operand_b), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_div0"}, 64'(div0_err), 64'd0);
        check({tag, "_issued"}, 64'(loads_issued), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_opcode = '0;
        in_operand_a = '0;
        in_operand_b = '0;
        start = 1'b0;
        start_addr = '0;
        load_count = '0;
        abort = 1'b0;
        repeat (2) tick();
        check_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // Preload four entries in IDLE; the fourth fills the FIFO.
        for (int i = 0; i < 4; i++) begin
            put(4'(i + 1), 32'(100 + i), 32'(200 + i));
            tick();
        end
        in_valid = 1'b0;
        check("pre_full", 64'(in_ready), 64'd0);
        check("pre_idle", 64'(busy), 64'd0);
        start = 1'b1;
        start_addr = 5'd2;
        load_count = 6'd4;
        tick();
        start = 1'b0;
        check("pre_busy", 64'(busy), 64'd1);
        check("pre_noload", 64'(load_en), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pre_en", 64'(load_en), 64'd1);
            check("pre_wp", 64'(write_pointer), 64'(2 + i));
            check("pre_opc", 64'(opcode), 64'(i + 1));
            check("pre_a", 64'(operand_a), 64'(100 + i));
            check("pre_b", 64'(operand_b), 64'(200 + i));
            check("pre_done", 64'(done), 64'(i == 3));
        end
        tick();
        check("pre_end_en", 64'(load_en), 64'd0);
        check("pre_end_done", 64'(done), 64'd0);
        check("pre_end_busy", 64'(busy), 64'd0);
        check("pre_issued", 64'(loads_issued), 64'd4);
        check("pre_ready", 64'(in_ready), 64'd1);

        // Continuous stream across the address wrap.
        start = 1'b1;
        start_addr = 5'd30;
        load_count = 6'd4;
        put(4'd7, 32'd0, 32'd1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) put(4'd7, 32'(i + 1), 32'd1);
            else in_valid = 1'b0;
            tick();
            check("wrap_en", 64'(load_en), 64'd1);
            check("wrap_wp", 64'(write_pointer), 64'((30 + i) % 32));
            check("wrap_a", 64'(operand_a), 64'(i));
            check("wrap_done", 64'(done), 64'(i == 3));
        end
        tick();
        check("wrap_idle", 64'(busy), 64'd0);

        // Gapped stream: each issue follows its accepted push by one edge.
        start = 1'b1;
        start_addr = 5'd0;
        load_count = 6'd3;
        tick();
        start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) put(4'd2, 32'(c), 32'd9);
            else in_valid = 1'b0;
            tick();
            check("gap_en", 64'(load_en),
                  64'(c >= 1 && (c - 1) % 3 == 0));
            check("gap_done", 64'(done), 64'(c == 7));
        end
        in_valid = 1'b0;
        check("gap_idle", 64'(busy), 64'd0);
        check("gap_issued", 64'(loads_issued), 64'd3);
        check("gap_wp", 64'(write_pointer), 64'd2);

        // DIV by zero sets the sticky flag; MOD 7,3 leaves it set.
        start = 1'b1;
        start_addr = 5'd5;
        load_count = 6'd2;
        put(4'd4, 32'd10, 32'd0);
        tick();
        start = 1'b0;
        check("div_pre", 64'(div0_err), 64'd0);
        put(4'd5, 32'd7, 32'd3);
        tick();
        in_valid = 1'b0;
        check("div_en", 64'(load_en), 64'd1);
        check("div_opc", 64'(opcode), 64'd4);
        check("div_b", 64'(operand_b), 64'd0);
        check("div_err", 64'(div0_err), 64'd1);
        tick();
        check("mod_opc", 64'(opcode), 64'd5);
        check("mod_err", 64'(div0_err), 64'd1);
        check("mod_done", 64'(done), 64'd1);
        tick();
        check("div_sticky", 64'(div0_err), 64'd1);
        start = 1'b1;
        load_count = 6'd1;
        tick();
        start = 1'b0;
        check("div_clr", 64'(div0_err), 64'd0);
        put(4'd5, 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("mod0_err", 64'(div0_err), 64'd1);
        check("mod0_done", 64'(done), 64'd1);
        tick();

        // Abort mid-run with two entries still queued.
        for (int i = 0; i < 3; i++) begin
            put(4'd3, 32'(i), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        start = 1'b1;
        start_addr = 5'd0;
        load_count = 6'd8;
        tick();
        start = 1'b0;
        tick();
        check("ab_first", 64'(load_en), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_en", 64'(load_en), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_ready", 64'(in_ready), 64'd1);
        check("ab_issued", 64'(loads_issued), 64'd1);
        check("ab_div0", 64'(div0_err), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ab_quiet_en", 64'(load_en), 64'd0);
            check("ab_quiet_done", 64'(done), 64'd0);
        end
        start = 1'b1;
        load_count = 6'd1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("ab_flushed", 64'(load_en), 64'd0);
        check("ab_run", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle", 64'(busy), 64'd0);

        // Asynchronous reset after three of eight loads.
        start = 1'b1;
        start_addr = 5'd9;
        load_count = 6'd8;
        put(4'd4, 32'd1, 32'd0);
        tick();
        start = 1'b0;
        put(4'd1, 32'd2, 32'd2);
        tick();
        put(4'd1, 32'd3, 32'd3);
        tick();
        in_valid = 1'b0;
        tick();
        check("mr_issued", 64'(loads_issued), 64'd3);
        check("mr_wp", 64'(write_pointer), 64'd11);
        reset_n = 1'b0;
        #1;
        check_all_zero("mr");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_post_en", 64'(load_en), 64'd0);
            check("mr_post_busy", 64'(busy), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
